// File: rtl/ws2811_seq_pkg.sv
// Shared types and default constants for the WS2811 frame sequencer.
package ws2811_seq_pkg;

  typedef logic [23:0] pixel_t;

  typedef enum logic [3:0] {
    IDLE,
    LOAD,
    FETCH,
    WAITDATA,
    SEND,
    DRAIN,
    LATCH,
    DONE,
    WAIT
  } seq_state_t;

  localparam int DEFAULT_LATCH_CYCLES = 5000;
  localparam int DEFAULT_PERIOD_W     = 24;

endpackage

// File: rtl/ws2811_seq_counter.sv
// Loadable saturating up-counter; tc_o is high while the count has reached limit_i.
module ws2811_seq_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  input  logic [WIDTH-1:0] limit_i,
  output logic             tc_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (en_i && (count_q != '1)) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc_o = (count_q >= limit_i);

endmodule

// File: rtl/ws2811_frame_sequencer.sv
// Walks the frame buffer, feeds GRB words to the serializer, then drains,
// holds the latch gap and paces frame starts against a programmable period.
module ws2811_frame_sequencer
  import ws2811_seq_pkg::*;
#(
  parameter int MAX_PIXELS   = 1024,
  parameter int ADDR_W       = 10,
  parameter int LATCH_CYCLES = DEFAULT_LATCH_CYCLES,
  parameter int PERIOD_W     = DEFAULT_PERIOD_W
) (
  input  logic                ACLK,
  input  logic                ARESETN,
  input  logic                cfg_enable,
  input  logic [ADDR_W:0]     cfg_num_pixels,
  input  logic [PERIOD_W-1:0] cfg_period,
  output logic                mem_rd_en,
  output logic [ADDR_W-1:0]   mem_rd_addr,
  input  logic [23:0]         mem_rd_data,
  output logic                px_valid,
  output logic [23:0]         px_data,
  input  logic                px_ready,
  input  logic                ser_busy,
  output logic                frame_done,
  output logic                overrun,
  output logic                busy,
  output logic [15:0]         frame_count
);

  localparam int                  LATCH_W    = $clog2(LATCH_CYCLES + 1);
  localparam logic [ADDR_W:0]     MAX_COUNT  = (ADDR_W + 1)'(MAX_PIXELS);
  localparam logic [LATCH_W-1:0]  LATCH_LAST = LATCH_W'(LATCH_CYCLES - 1);

  seq_state_t          state_q, state_d;
  logic [ADDR_W:0]     index_q, index_d;
  logic [ADDR_W:0]     num_q, num_d;
  logic [PERIOD_W-1:0] period_q, period_d;
  pixel_t              px_data_q, px_data_d;
  logic                frame_done_q, frame_done_d;
  logic                overrun_q, overrun_d;
  logic [15:0]         frame_count_q, frame_count_d;

  logic                handshake, last_px, period_ok, latch_tc;
  logic                per_load, lat_load, lat_en;
  logic [PERIOD_W-1:0] period_limit;

  assign handshake    = (state_q == SEND) && px_ready;
  assign last_px      = (index_q == num_q - (ADDR_W + 1)'(1));
  // Period 0 and 1 both collapse to a limit of 0: back-to-back frames.
  assign period_limit = (period_q == '0) ? '0 : period_q - PERIOD_W'(1);

  // The counter is loaded with 1 in LOAD so that its value equals cycles since LOAD.
  ws2811_seq_counter #(.WIDTH(PERIOD_W)) u_period_cnt (
    .clk_i      (ACLK),
    .rst_ni     (ARESETN),
    .load_i     (per_load),
    .load_val_i (PERIOD_W'(1)),
    .en_i       (1'b1),
    .limit_i    (period_limit),
    .tc_o       (period_ok)
  );

  ws2811_seq_counter #(.WIDTH(LATCH_W)) u_latch_cnt (
    .clk_i      (ACLK),
    .rst_ni     (ARESETN),
    .load_i     (lat_load),
    .load_val_i ('0),
    .en_i       (lat_en),
    .limit_i    (LATCH_LAST),
    .tc_o       (latch_tc)
  );

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q       <= IDLE;
      index_q       <= '0;
      num_q         <= '0;
      period_q      <= '0;
      px_data_q     <= '0;
      frame_done_q  <= 1'b0;
      overrun_q     <= 1'b0;
      frame_count_q <= '0;
    end else begin
      state_q       <= state_d;
      index_q       <= index_d;
      num_q         <= num_d;
      period_q      <= period_d;
      px_data_q     <= px_data_d;
      frame_done_q  <= frame_done_d;
      overrun_q     <= overrun_d;
      frame_count_q <= frame_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    index_d       = index_q;
    num_d         = num_q;
    period_d      = period_q;
    px_data_d     = px_data_q;
    case (state_q)
      IDLE:     if (cfg_enable && (cfg_num_pixels != '0)) state_d = LOAD;
      LOAD: begin
        state_d  = FETCH;
        index_d  = '0;
        num_d    = (cfg_num_pixels > MAX_COUNT) ? MAX_COUNT : cfg_num_pixels;
        period_d = cfg_period;
      end
      FETCH:    state_d = WAITDATA;
      WAITDATA: begin
        state_d   = SEND;
        px_data_d = mem_rd_data;
      end
      SEND: if (handshake) begin
        index_d = index_q + (ADDR_W + 1)'(1);
        state_d = last_px ? DRAIN : FETCH;
      end
      DRAIN:    if (!ser_busy) state_d = LATCH;
      LATCH:    if (latch_tc) state_d = DONE;
      DONE:     state_d = WAIT;
      WAIT: begin
        if (!cfg_enable)     state_d = IDLE;
        else if (period_ok)  state_d = LOAD;
      end
      default:  state_d = IDLE;
    endcase
    // Pulses are registered so they line up exactly with the DONE cycle.
    frame_done_d  = (state_d == DONE);
    overrun_d     = (state_d == DONE) && (period_q != '0) && period_ok;
    frame_count_d = frame_count_q + ((state_d == DONE) ? 16'd1 : 16'd0);
  end

  always_comb begin
    mem_rd_en = (state_q == FETCH);
    px_valid  = (state_q == SEND);
    busy      = (state_q != IDLE);
    per_load  = (state_q == LOAD);
    lat_load  = (state_q != LATCH);
    lat_en    = (state_q == LATCH);
  end

  assign mem_rd_addr = index_q[ADDR_W-1:0];
  assign px_data     = px_data_q;
  assign frame_done  = frame_done_q;
  assign overrun     = overrun_q;
  assign frame_count = frame_count_q;

endmodule

// File: tb/tb_ws2811_frame_sequencer.sv
// Directed bench for ws2811_frame_sequencer: cycle-stamped event log checked
// against hand-computed frame timing with LATCH_CYCLES=8.
module tb_ws2811_frame_sequencer;

  localparam int LAT = 8;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic        cfg_enable = 1'b0;
  logic [10:0] cfg_num_pixels = '0;
  logic [23:0] cfg_period = '0;
  logic        mem_rd_en;
  logic [9:0]  mem_rd_addr;
  logic [23:0] mem_rd_data = '0;
  logic        px_valid;
  logic [23:0] px_data;
  logic        px_ready = 1'b1;
  logic        ser_busy = 1'b0;
  logic        frame_done;
  logic        overrun;
  logic        busy;
  logic [15:0] frame_count;

  ws2811_frame_sequencer #(
    .MAX_PIXELS   (1024),
    .ADDR_W       (10),
    .LATCH_CYCLES (LAT),
    .PERIOD_W     (24)
  ) dut (
    .ACLK           (ACLK),
    .ARESETN        (ARESETN),
    .cfg_enable     (cfg_enable),
    .cfg_num_pixels (cfg_num_pixels),
    .cfg_period     (cfg_period),
    .mem_rd_en      (mem_rd_en),
    .mem_rd_addr    (mem_rd_addr),
    .mem_rd_data    (mem_rd_data),
    .px_valid       (px_valid),
    .px_data        (px_data),
    .px_ready       (px_ready),
    .ser_busy       (ser_busy),
    .frame_done     (frame_done),
    .overrun        (overrun),
    .busy           (busy),
    .frame_count    (frame_count)
  );

  always #5 ACLK = ~ACLK;

  logic [23:0] mem [1024];
  always @(posedge ACLK) if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  int t0 = 0;
  int mon_rel;
  int rd_addr[$], rd_cyc[$], hs_cyc[$], hs_data[$], stall_data[$], done_cyc[$], ov_cyc[$];
  int busy_cnt = 0;
  int n_checks = 0;
  int n_pass = 0;

  // Event log, sampled mid-cycle after the input driver has settled.
  always begin
    @(negedge ACLK);
    #2;
    mon_rel = cyc - t0;
    if (mem_rd_en) begin
      rd_addr.push_back(int'(mem_rd_addr));
      rd_cyc.push_back(mon_rel);
    end
    if (px_valid && px_ready) begin
      hs_cyc.push_back(mon_rel);
      hs_data.push_back(int'(px_data));
    end
    if (px_valid && !px_ready) stall_data.push_back(int'(px_data));
    if (frame_done) done_cyc.push_back(mon_rel);
    if (overrun) ov_cyc.push_back(mon_rel);
    if (busy) busy_cnt++;
  end

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic start_frame(input int nump, input int period);
    @(negedge ACLK);
    cfg_num_pixels = 11'(nump);
    cfg_period     = 24'(period);
    cfg_enable     = 1'b1;
    t0             = cyc;
    rd_addr.delete(); rd_cyc.delete(); hs_cyc.delete(); hs_data.delete();
    stall_data.delete(); done_cyc.delete(); ov_cyc.delete();
    busy_cnt = 0;
  endtask

  task automatic wait_rel(input int n);
    while ((cyc - t0) < n) @(negedge ACLK);
  endtask

  task automatic do_reset();
    @(negedge ACLK);
    ARESETN = 1'b0; cfg_enable = 1'b0; px_ready = 1'b1; ser_busy = 1'b0;
    @(negedge ACLK);
    ARESETN = 1'b1;
  endtask

  initial begin
    for (int a = 0; a < 1024; a++) mem[a] = 24'h0A0000 + 24'(a);

    repeat (3) @(negedge ACLK);
    check("reset_px_valid", px_valid, 0);
    check("reset_rd_en", mem_rd_en, 0);
    check("reset_busy", busy, 0);
    check("reset_done", frame_done, 0);
    check("reset_px_data", px_data, 0);
    check("reset_frame_count", frame_count, 0);
    ARESETN = 1'b1;

    // Back-to-back frames
    start_frame(4, 0);
    wait_rel(30);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("b2b_rd_addr%0d", i), qget(rd_addr, i), i);
      check($sformatf("b2b_hs_cyc%0d", i), qget(hs_cyc, i), 4 + 3 * i);
      check($sformatf("b2b_hs_data%0d", i), qget(hs_data, i), 32'h0A0000 + i);
    end
    check("b2b_done_cyc", qget(done_cyc, 0), 23);
    check("b2b_next_fetch_addr", qget(rd_addr, 4), 0);
    check("b2b_next_fetch_cyc", qget(rd_cyc, 4), 26);
    check("b2b_frame_count", frame_count, 1);

    // Backpressure on pixel 2
    do_reset();
    start_frame(4, 0);
    wait_rel(10); px_ready = 1'b0;
    wait_rel(15); px_ready = 1'b1;
    wait_rel(30);
    check("bp_stall_cycles", stall_data.size(), 5);
    for (int i = 0; i < stall_data.size(); i++)
      check($sformatf("bp_stall_data%0d", i), stall_data[i], 32'h0A0002);
    check("bp_hs2_cyc", qget(hs_cyc, 2), 15);
    check("bp_hs2_data", qget(hs_data, 2), 32'h0A0002);
    check("bp_done_cyc", qget(done_cyc, 0), 28);

    // Serializer drain
    do_reset();
    start_frame(4, 0);
    wait_rel(14); ser_busy = 1'b1;
    wait_rel(30);
    check("drain_busy", busy, 1);
    wait_rel(34); ser_busy = 1'b0;
    wait_rel(50);
    check("drain_done_cyc", qget(done_cyc, 0), 43);

    // Period 100: frames start 100 cycles apart, no overrun
    do_reset();
    start_frame(4, 100);
    wait_rel(250);
    check("p100_fetch0", qget(rd_cyc, 0), 2);
    check("p100_fetch1", qget(rd_cyc, 4), 102);
    check("p100_fetch2", qget(rd_cyc, 8), 202);
    check("p100_fetch2_addr", qget(rd_addr, 8), 0);
    check("p100_dones", done_cyc.size(), 3);
    check("p100_overruns", ov_cyc.size(), 0);

    // Period 10: every frame overruns, frames run back-to-back
    do_reset();
    start_frame(4, 10);
    wait_rel(80);
    check("p10_dones", done_cyc.size(), 3);
    check("p10_overruns", ov_cyc.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("p10_done_cyc%0d", i), qget(done_cyc, i), 23 + 24 * i);
      check($sformatf("p10_ov_cyc%0d", i), qget(ov_cyc, i), 23 + 24 * i);
    end

    // Enable dropped mid-frame
    do_reset();
    start_frame(4, 0);
    wait_rel(8); cfg_enable = 1'b0;
    wait_rel(60);
    check("endrop_hs", hs_cyc.size(), 4);
    check("endrop_reads", rd_cyc.size(), 4);
    check("endrop_dones", done_cyc.size(), 1);
    check("endrop_done_cyc", qget(done_cyc, 0), 23);
    check("endrop_busy", busy, 0);

    // Zero pixels: stay idle
    do_reset();
    start_frame(0, 0);
    wait_rel(200);
    check("zero_reads", rd_cyc.size(), 0);
    check("zero_busy_cycles", busy_cnt, 0);
    check("zero_dones", done_cyc.size(), 0);

    // Count clamp to 1024
    do_reset();
    start_frame(2000, 0);
    wait_rel(8); cfg_enable = 1'b0;
    wait_rel(3095);
    check("clamp_hs", hs_cyc.size(), 1024);
    check("clamp_last_data", qget(hs_data, 1023), 32'h0A03FF);
    check("clamp_last_cyc", qget(hs_cyc, 1023), 3073);
    check("clamp_done_cyc", qget(done_cyc, 0), 3083);
    check("clamp_dones", done_cyc.size(), 1);

    // Reset while in SEND of the second frame
    do_reset();
    start_frame(4, 0);
    wait_rel(28);
    check("rst_in_send", px_valid, 1);
    check("rst_pre_count", frame_count, 1);
    ARESETN = 1'b0; cfg_enable = 1'b0;
    wait_rel(29);
    check("rst_px_valid", px_valid, 0);
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_busy", busy, 0);
    check("rst_px_data", px_data, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_done", frame_done, 0);
    check("rst_dones_logged", done_cyc.size(), 1);
    ARESETN = 1'b1;
    start_frame(4, 0);
    wait_rel(12);
    check("rst_restart_addr", qget(rd_addr, 0), 0);
    check("rst_restart_rd_cyc", qget(rd_cyc, 0), 2);
    check("rst_restart_hs_cyc", qget(hs_cyc, 0), 4);
    check("rst_restart_hs_data", qget(hs_data, 0), 32'h0A0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
